rsa_stream_frontend: RTL and testbench

- Byte-stream front end placed directly upstream and downstream of Rsa256Core.
- Assembles modulus N, exponent D and ciphertext A from an 8-bit valid/ready stream (MSB byte first), pulses the core start, and captures the core result.
- Streams the decrypted plaintext back out as bytes; the top byte of the result is dropped (plaintext is 248 bits).
- Key is loaded once after reset; ciphertext blocks then repeat until a key reload is requested.

---
 rtl/rsa_stream_frontend.sv | 197 +++++++++++++++++++
 tb/tb_rsa_stream_frontend.sv | 384 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rsa_stream_frontend.sv
// Byte-stream front end for a 256-bit modexp core: loads N, D, A MSB-first, pulses start,
// captures the result and streams its low OUT_BYTES bytes out. RSA_TIMEOUT_EN adds a core watchdog.
module rsa_stream_frontend #(
  parameter int unsigned KEY_BYTES   = 32,
  parameter int unsigned OUT_BYTES   = 31,
  parameter int unsigned TIMEOUT_CYC = 600000
) (
  input  logic                   i_clk,
  input  logic                   i_rst_n,
  input  logic [7:0]             i_rx_data,
  input  logic                   i_rx_valid,
  output logic                   o_rx_ready,
  output logic [7:0]             o_tx_data,
  output logic                   o_tx_valid,
  input  logic                   i_tx_ready,
  input  logic                   i_key_reload,
  output logic                   o_core_start,
  output logic [8*KEY_BYTES-1:0] o_core_a,
  output logic [8*KEY_BYTES-1:0] o_core_n,
  output logic [8*KEY_BYTES-1:0] o_core_d,
  input  logic [8*KEY_BYTES-1:0] i_core_result,
  input  logic                   i_core_finished,
  output logic                   o_busy,
  output logic                   o_error
);

  localparam int unsigned W    = 8 * KEY_BYTES;
  localparam int unsigned CntW = $clog2(KEY_BYTES);
  localparam int unsigned IdxW = $clog2(W);
  localparam logic [CntW-1:0] KeyLast = CntW'(KEY_BYTES - 1);
  localparam logic [CntW-1:0] OutLast = CntW'(OUT_BYTES - 1);

  if (OUT_BYTES > KEY_BYTES || OUT_BYTES == 0 || KEY_BYTES < 2 || TIMEOUT_CYC == 0)
  begin : gen_cfg_check
    $error("rsa_stream_frontend: illegal parameter combination");
  end

  typedef enum logic [2:0] {StKeyN, StKeyD, StData, StStart, StWait, StSend} state_e;

  state_e          state_d, state_q;
  logic [CntW-1:0] cnt_d, cnt_q;
  logic [W-1:0]    n_d, n_q, d_d, d_q, a_d, a_q, res_d, res_q;
  logic            reload_d, reload_q;
  logic            rx_ready_d, rx_ready_q;
  logic            tx_valid_d, tx_valid_q;
  logic [7:0]      tx_data_d, tx_data_q;
  logic            start_d, start_q;
  logic            busy_d, busy_q;
  logic [IdxW-1:0] tx_lsb;
  logic            rx_fire, tx_fire, timeout;

  assign rx_fire = rx_ready_q & i_rx_valid;
  assign tx_fire = tx_valid_q & i_tx_ready;

`ifdef RSA_TIMEOUT_EN
  logic [31:0] wd_d, wd_q;
  logic        error_d, error_q;

  assign timeout = (state_q == StWait) && !i_core_finished && (wd_q == 32'(TIMEOUT_CYC - 1));
  assign wd_d    = (state_q == StWait) ? wd_q + 32'd1 : '0;
  assign error_d = error_q | timeout;
  assign o_error = error_q;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      wd_q    <= '0;
      error_q <= 1'b0;
    end else begin
      wd_q    <= wd_d;
      error_q <= error_d;
    end
  end
`else
  assign timeout = 1'b0;
  assign o_error = 1'b0;
`endif

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    n_d      = n_q;
    d_d      = d_q;
    a_d      = a_q;
    res_d    = res_q;
    reload_d = reload_q | i_key_reload;
    unique case (state_q)
      StKeyN: begin
        reload_d = 1'b0;
        if (rx_fire) begin
          n_d   = {n_q[W-9:0], i_rx_data};
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == KeyLast) begin
            cnt_d   = '0;
            state_d = StKeyD;
          end
        end
      end
      StKeyD: begin
        reload_d = 1'b0;
        if (rx_fire) begin
          d_d   = {d_q[W-9:0], i_rx_data};
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == KeyLast) begin
            cnt_d   = '0;
            state_d = StData;
          end
        end
      end
      StData: begin
        // A reload only preempts a block that has not started yet.
        if (reload_q && cnt_q == '0) begin
          reload_d = 1'b0;
          state_d  = StKeyN;
        end else if (rx_fire) begin
          a_d   = {a_q[W-9:0], i_rx_data};
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == KeyLast) begin
            cnt_d   = '0;
            state_d = StStart;
          end
        end
      end
      StStart: state_d = StWait;
      StWait: begin
        if (i_core_finished) begin
          res_d   = i_core_result;
          cnt_d   = '0;
          state_d = StSend;
        end else if (timeout) begin
          cnt_d   = '0;
          state_d = StData;
        end
      end
      StSend: begin
        if (tx_fire) begin
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == OutLast) begin
            cnt_d   = '0;
            state_d = StData;
          end
        end
      end
      default: state_d = StKeyN;
    endcase
  end

  // Outputs are registered from the next state so they line up with state_q.
  always_comb begin
    rx_ready_d = (state_d == StKeyN) || (state_d == StKeyD) ||
                 ((state_d == StData) && !(reload_d && cnt_d == '0));
    start_d    = (state_d == StStart);
    busy_d     = (state_d == StStart) || (state_d == StWait) || (state_d == StSend);
    tx_valid_d = (state_d == StSend);
    tx_lsb     = IdxW'(OutLast - cnt_d) << 3;
    tx_data_d  = tx_valid_d ? res_d[tx_lsb +: 8] : tx_data_q;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q    <= StKeyN;
      cnt_q      <= '0;
      n_q        <= '0;
      d_q        <= '0;
      a_q        <= '0;
      res_q      <= '0;
      reload_q   <= 1'b0;
      rx_ready_q <= 1'b0;
      tx_valid_q <= 1'b0;
      tx_data_q  <= '0;
      start_q    <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      n_q        <= n_d;
      d_q        <= d_d;
      a_q        <= a_d;
      res_q      <= res_d;
      reload_q   <= reload_d;
      rx_ready_q <= rx_ready_d;
      tx_valid_q <= tx_valid_d;
      tx_data_q  <= tx_data_d;
      start_q    <= start_d;
      busy_q     <= busy_d;
    end
  end

  assign o_rx_ready   = rx_ready_q;
  assign o_tx_valid   = tx_valid_q;
  assign o_tx_data    = tx_data_q;
  assign o_core_start = start_q;
  assign o_busy       = busy_q;
  assign o_core_a     = a_q;
  assign o_core_n     = n_q;
  assign o_core_d     = d_q;

endmodule

// File: tb/tb_rsa_stream_frontend.sv
// Self-checking bench for rsa_stream_frontend: directed key/ciphertext streams, a stand-in core
// returning A xor D, and a byte/block scoreboard checked every cycle.
module tb_rsa_stream_frontend;

  localparam int unsigned KB = 32;
  localparam int unsigned OB = 31;
  localparam int unsigned W  = 8 * KB;

  typedef logic [W-1:0] word_t;
  typedef struct packed { word_t a; word_t n; word_t d; } blk_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic [7:0] rx_data = '0;
  logic       rx_valid = 1'b0;
  logic       rx_ready;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready = 1'b1;
  logic       key_reload = 1'b0;
  logic       core_start;
  word_t      core_a, core_n, core_d;
  word_t      core_result = '0;
  logic       core_finished = 1'b0;
  logic       busy, error;

  always #5 clk = ~clk;

  rsa_stream_frontend #(.KEY_BYTES(KB), .OUT_BYTES(OB)) dut (
    .i_clk           (clk),
    .i_rst_n         (rst_n),
    .i_rx_data       (rx_data),
    .i_rx_valid      (rx_valid),
    .o_rx_ready      (rx_ready),
    .o_tx_data       (tx_data),
    .o_tx_valid      (tx_valid),
    .i_tx_ready      (tx_ready),
    .i_key_reload    (key_reload),
    .o_core_start    (core_start),
    .o_core_a        (core_a),
    .o_core_n        (core_n),
    .o_core_d        (core_d),
    .i_core_result   (core_result),
    .i_core_finished (core_finished),
    .o_busy          (busy),
    .o_error         (error)
  );

  int         total = 0;
  int         bad = 0;
  int         starts = 0;
  int         stall_cycles = 0;
  logic [7:0] exp_bytes[$];
  blk_t       exp_blk[$];
  logic [7:0] tx_log[$];
  bit         rx_last = 0;
  int         gap_max = 0;
  bit         core_en = 1;
  bit         spurious = 0;
  bit         stall_arm = 0;
  int         stall_seen = 0;
  int         stall_left = 0;
  word_t      cur_n = '0;
  word_t      cur_d = '0;

  task automatic chk(input string name, input word_t act, input word_t exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Stand-in core: answers A xor D four cycles after start.
  initial begin : core_model
    bit    pend;
    int    dly;
    word_t res;
    pend = 0;
    dly  = 0;
    res  = '0;
    forever begin
      @(posedge clk);
      #1;
      core_finished = 1'b0;
      if (!rst_n) begin
        pend = 0;
      end else if (spurious) begin
        core_finished = 1'b1;
        core_result   = {8{32'h5EED_F00D}};
        spurious      = 0;
      end else if (pend) begin
        if (dly == 0) begin
          core_finished = 1'b1;
          core_result   = res;
          pend          = 0;
        end else begin
          dly--;
        end
      end
      if (rst_n && core_start && core_en) begin
        pend = 1;
        dly  = 3;
        res  = core_a ^ core_d;
      end
    end
  end

  // Sink: after 10 accepted bytes of an armed block, refuse for 7 cycles.
  initial begin : sink
    forever begin
      @(negedge clk);
      if (stall_arm && tx_valid && tx_ready) begin
        stall_seen++;
        if (stall_seen == 10) begin
          stall_arm  = 0;
          stall_left = 7;
        end
      end
      @(posedge clk);
      #1;
      if (stall_left > 0) begin
        tx_ready = 1'b0;
        stall_left--;
      end else begin
        tx_ready = 1'b1;
      end
    end
  end

  initial begin : compare
    bit         start_due, tx_due, waiting, hold;
    logic [7:0] hold_data;
    blk_t       snap;
    start_due = 0;
    tx_due    = 0;
    waiting   = 0;
    hold      = 0;
    hold_data = '0;
    snap      = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        exp_bytes.delete();
        exp_blk.delete();
        start_due = 0;
        tx_due    = 0;
        waiting   = 0;
        hold      = 0;
      end else begin
        chk("start_timing", core_start, start_due);
        if (core_start) begin
          starts++;
          if (exp_blk.size() == 0) begin
            total++;
            bad++;
            $display("FAIL start_unexpected: got start pulse, expected none");
            snap = {core_a, core_n, core_d};
          end else begin
            snap = exp_blk.pop_front();
            chk("core_a_at_start", core_a, snap.a);
            chk("core_n_at_start", core_n, snap.n);
            chk("core_d_at_start", core_d, snap.d);
          end
          waiting = 1;
        end else if (waiting) begin
          chk("core_a_hold", core_a, snap.a);
          chk("core_n_hold", core_n, snap.n);
          chk("core_d_hold", core_d, snap.d);
        end
        start_due = rx_valid && rx_ready && rx_last;
        if (tx_due) chk("tx_latency", tx_valid, 1);
        tx_due = waiting && core_finished && !core_start;
        if (tx_due) waiting = 0;
        if (hold) begin
          chk("tx_hold_valid", tx_valid, 1);
          chk("tx_hold_data", tx_data, hold_data);
        end
        hold      = tx_valid && !tx_ready;
        hold_data = tx_data;
        if (tx_valid && !tx_ready) stall_cycles++;
        if (tx_valid && tx_ready) begin
          tx_log.push_back(tx_data);
          if (exp_bytes.size() == 0) begin
            total++;
            bad++;
            $display("FAIL tx_unexpected: got byte %0h, expected none", tx_data);
          end else begin
            chk("tx_byte", tx_data, exp_bytes.pop_front());
          end
        end
      end
    end
  end

  task automatic send_byte(input logic [7:0] b, input bit last);
    int guard;
    bit ok;
    repeat (int'($urandom_range(gap_max))) begin
      @(posedge clk);
      #1;
    end
    rx_data  = b;
    rx_valid = 1'b1;
    rx_last  = last;
    guard    = 0;
    ok       = 0;
    while (!ok && guard < 400) begin
      @(negedge clk);
      ok = rx_ready;
      @(posedge clk);
      #1;
      guard++;
    end
    rx_valid = 1'b0;
    rx_last  = 0;
    if (!ok) begin
      total++;
      bad++;
      $display("FAIL rx_accept: byte %0h not accepted within 400 cycles", b);
    end
  endtask

  task automatic send_word(input word_t w, input bit last);
    for (int i = KB - 1; i >= 0; i--) send_byte(w[8*i +: 8], last && (i == 0));
  endtask

  task automatic send_key(input word_t n, input word_t d);
    send_word(n, 0);
    send_word(d, 0);
    cur_n = n;
    cur_d = d;
  endtask

  task automatic send_block(input word_t a);
    word_t r;
    r = a ^ cur_d;
    exp_blk.push_back({a, cur_n, cur_d});
    for (int i = OB - 1; i >= 0; i--) exp_bytes.push_back(r[8*i +: 8]);
    send_word(a, 1);
  endtask

  task automatic wait_idle(input string name);
    int guard;
    guard = 0;
    do begin
      @(negedge clk);
      guard++;
    end while ((exp_bytes.size() != 0 || busy) && guard < 3000);
    if (guard >= 3000) begin
      total++;
      bad++;
      $display("FAIL %s_idle: still busy after 3000 cycles, %0d bytes pending", name,
               exp_bytes.size());
    end
    @(posedge clk);
    #1;
  endtask

  function automatic word_t rand_word();
    word_t r;
    for (int i = 0; i < 8; i++) r[32*i +: 32] = $urandom;
    return r;
  endfunction

  task automatic chk_all_zero(input string tag);
    chk({tag, "_rx_ready"}, rx_ready, 0);
    chk({tag, "_tx_valid"}, tx_valid, 0);
    chk({tag, "_tx_data"}, tx_data, 0);
    chk({tag, "_core_start"}, core_start, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_error"}, error, 0);
    chk({tag, "_core_a"}, core_a, 0);
    chk({tag, "_core_n"}, core_n, 0);
    chk({tag, "_core_d"}, core_d, 0);
  endtask

  initial begin : watchdog
    #600000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin : main
    word_t n1, d1, a0, n2, d2;
    int    guard;
    n1 = 256'hCA3586E7_11223344_55667788_99AABBCC_DDEEFF00_12345678_9ABCDEF0_029CF831;
    d1 = 256'hB6ACE0B1_0F1E2D3C_4B5A6978_8796A5B4_C3D2E1F0_01020304_05060708_BCF46BD9;
    a0 = 256'h01C0FFEE_13579BDF_2468ACE0_0F0F0F0F_F0F0F0F0_A5A5A5A5_5A5A5A5A_DEADBEEF;
    n2 = 256'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210_1111_2222_3333_4444_5555_6666_7777_8888;
    d2 = 256'h8000_0000_0000_0000_0000_0000_0000_0000_0000_0000_0000_0000_0000_0000_0001_0001;

    #1 rst_n = 1'b0;
    #1 chk_all_zero("reset");
    @(posedge clk);
    @(posedge clk);
    #3 rst_n = 1'b1;
    @(posedge clk);
    #1 chk("rx_ready_after_reset", rx_ready, 1);

    // Key load and one block: R = A ^ D, bytes R[247:0] MSB first.
    gap_max = 0;
    send_key(n1, d1);
    send_block(a0);
    wait_idle("block0");
    chk("starts_block0", starts, 1);
    chk("tx_count_block0", tx_log.size(), 31);
    chk("tx_first_byte", tx_log[0], 8'h6C);
    chk("tx_second_byte", tx_log[1], 8'h1F);
    chk("tx_last_byte", tx_log[30], 8'h36);
    chk("core_n_key1", core_n, n1);
    chk("core_d_key1", core_d, d1);

    // Backpressure mid-send and gappy rx.
    gap_max    = 3;
    stall_seen = 0;
    stall_arm  = 1;
    send_block(rand_word());
    wait_idle("stall");
    chk("stall_cycles", stall_cycles, 7);
    chk("tx_count_stall", tx_log.size(), 62);

    // Five back-to-back blocks on the same key.
    gap_max = 2;
    for (int b = 0; b < 5; b++) send_block(rand_word());
    wait_idle("b2b");
    chk("starts_b2b", starts, 7);
    chk("tx_count_b2b", tx_log.size(), 217);
    chk("core_n_b2b", core_n, n1);
    chk("core_d_b2b", core_d, d1);

    // Reload requested while sending: block completes, then next 64 bytes are the new key.
    gap_max = 0;
    send_block(rand_word());
    guard = 0;
    do begin
      @(negedge clk);
      guard++;
    end while (!tx_valid && guard < 200);
    chk("reload_saw_tx_valid", tx_valid, 1);
    @(posedge clk);
    #1 key_reload = 1'b1;
    @(posedge clk);
    #1 key_reload = 1'b0;
    send_key(n2, d2);
    send_block(rand_word());
    wait_idle("reload");
    chk("starts_reload", starts, 9);
    chk("tx_count_reload", tx_log.size(), 279);
    chk("core_n_key2", core_n, n2);
    chk("core_d_key2", core_d, d2);

    // Async reset while waiting on a silent core.
    core_en = 0;
    send_block(rand_word());
    repeat (10) @(posedge clk);
    #1 chk("busy_in_wait", busy, 1);
    chk("starts_before_reset", starts, 10);
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1 chk_all_zero("async_reset");
    #20 rst_n = 1'b1;
    core_en = 1;
    @(negedge clk);
    spurious = 1;
    repeat (20) @(posedge clk);
    #1 chk("tx_count_after_spurious", tx_log.size(), 279);
    chk("rx_ready_after_async_reset", rx_ready, 1);
    chk("busy_after_async_reset", busy, 0);

    // Fresh key and block after the abort.
    send_key(n1, d1);
    send_block(rand_word());
    wait_idle("recover");
    chk("starts_final", starts, 11);
    chk("tx_count_final", tx_log.size(), 310);
    chk("core_n_final", core_n, n1);
    chk("error_final", error, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
